// File: rtl/cfeb_hdr_pkg.sv
// Shared definitions for the CFEB per-sample serial header receiver:
// field bit positions, header length, FSM states and small decode helpers.
package cfeb_hdr_pkg;

    localparam int HDR_WORDS = 16;
    localparam int L1P_LSB   = 0;
    localparam int BLK_LSB   = 8;
    localparam int L1APH_BIT = 12;
    localparam int LCTPH_BIT = 13;
    localparam int SCAF_BIT  = 14;
    localparam int PAD_BIT   = 15;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } hdr_state_e;

    typedef struct packed {
        logic [7:0] l1p;
        logic [3:0] blk;
        logic       l1a_phase;
        logic       lct_phase;
        logic       scafull;
        logic       pad;
    } hdr_fields_t;

    function automatic hdr_fields_t decode_hdr(input logic [HDR_WORDS-1:0] w);
        hdr_fields_t f;
        f.l1p       = w[L1P_LSB +: 8];
        f.blk       = w[BLK_LSB +: 4];
        f.l1a_phase = w[L1APH_BIT];
        f.lct_phase = w[LCTPH_BIT];
        f.scafull   = w[SCAF_BIT];
        f.pad       = w[PAD_BIT];
        return f;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/cfeb_hdr_shreg.sv
// 16-bit header shadow shift register with word counter; done_o marks the
// 16th PUSH and word_o presents the completed word (including the current bit).
module cfeb_hdr_shreg
    import cfeb_hdr_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 push_i,
    input  logic                 din_i,
    input  logic                 last_i,
    output logic [HDR_WORDS-1:0] word_o,
    output logic                 done_o
);

    logic [HDR_WORDS-1:0] sh_q, sh_d;
    logic [3:0]           w_q, w_d;

    // Bits enter at the MSB, so after 16 pushes word 0 sits at bit 0.
    assign word_o = {din_i, sh_q[HDR_WORDS-1:1]};
    assign done_o = push_i && (w_q == 4'(HDR_WORDS - 1));

    always_comb begin
        sh_d = sh_q;
        w_d  = w_q;
        if (push_i) begin
            sh_d = word_o;
            w_d  = (done_o || last_i) ? 4'd0 : w_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q <= '0;
            w_q  <= '0;
        end else begin
            sh_q <= sh_d;
            w_q  <= w_d;
        end
    end

endmodule

// File: rtl/cfeb_hdr_rcvr.sv
// CFEB serial header receiver: FSM, sample/event counters, checks and output
// registers. Define HDR_CHK_EN to enable the pad and block-address checks.
module cfeb_hdr_rcvr
    import cfeb_hdr_pkg::*;
#(
    parameter int MAX_SMPS = 8
) (
    input  logic       CLK,
    input  logic       RST_B,
    input  logic       PUSH,
    input  logic       D13IN,
    input  logic       D14IN,
    input  logic       LASTWORD,
    input  logic       CLR_ERR,
    output logic       HDR_VLD,
    output logic [7:0] L1P,
    output logic [3:0] BLK_ADR,
    output logic       L1A_PHASE,
    output logic       LCT_PHASE,
    output logic       SCAFULL,
    output logic       OVLP,
    output logic [3:0] SMP_CNT,
    output logic       EVT_DONE,
    output logic [3:0] EVT_SMPS,
    output logic       ERR_PAD,
    output logic       ERR_BLK,
    output logic       ERR_LEN,
    output logic       DBG_STATE
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_SMPS);

    logic [HDR_WORDS-1:0] sh_word;
    logic                 smp_done;
    hdr_fields_t          f;

    cfeb_hdr_shreg u_shreg (
        .clk_i   (CLK),
        .rst_n_i (RST_B),
        .push_i  (PUSH),
        .din_i   (D13IN),
        .last_i  (LASTWORD),
        .word_o  (sh_word),
        .done_o  (smp_done)
    );

    assign f = decode_hdr(sh_word);

    hdr_state_e  state_q, state_d;
    logic [7:0]  l1p_q, l1p_d;
    logic [3:0]  blk_q, blk_d;
    logic        l1aph_q, l1aph_d;
    logic        lctph_q, lctph_d;
    logic        scaf_q, scaf_d;
    logic        ovlp_q, ovlp_d;
    logic [3:0]  smp_cnt_q, smp_cnt_d;
    logic [3:0]  evt_smps_q, evt_smps_d;
    logic        hdr_vld_q, hdr_vld_d;
    logic        evt_done_q, evt_done_d;
    logic        err_pad_q, err_pad_d;
    logic        err_blk_q, err_blk_d;
    logic        err_len_q, err_len_d;

    logic        evt_end;
    logic [3:0]  cnt_inc;
    logic        pad_set;
    logic        blk_set;
    logic        len_set;

    assign evt_end = PUSH && LASTWORD;
    assign cnt_inc = sat_inc4(smp_cnt_q);
    // A LASTWORD that does not close a full sample is a short event.
    assign len_set = (smp_done && (cnt_inc > MAX_CNT)) || (evt_end && !smp_done);

`ifdef HDR_CHK_EN
    logic [3:0] blk0_q;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            blk0_q <= '0;
        end else if (smp_done && (smp_cnt_q == 4'd0)) begin
            blk0_q <= f.blk;
        end
    end

    assign pad_set = smp_done && f.pad;
    assign blk_set = smp_done && (smp_cnt_q != 4'd0) && (f.blk != blk0_q);
`else
    logic unused_pad;
    assign unused_pad = f.pad;
    assign pad_set    = 1'b0;
    assign blk_set    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        l1p_d      = l1p_q;
        blk_d      = blk_q;
        l1aph_d    = l1aph_q;
        lctph_d    = lctph_q;
        scaf_d     = scaf_q;
        ovlp_d     = ovlp_q;
        smp_cnt_d  = smp_cnt_q;
        evt_smps_d = evt_smps_q;
        hdr_vld_d  = smp_done;
        evt_done_d = evt_end;

        if (smp_done) begin
            l1p_d     = f.l1p;
            blk_d     = f.blk;
            l1aph_d   = f.l1a_phase;
            lctph_d   = f.lct_phase;
            scaf_d    = f.scafull;
            ovlp_d    = !D14IN;
            smp_cnt_d = cnt_inc;
        end

        if (PUSH) begin
            state_d = evt_end ? IDLE : COLLECT;
        end

        if (evt_end) begin
            evt_smps_d = smp_done ? cnt_inc : smp_cnt_q;
            smp_cnt_d  = 4'd0;
        end

        // Set has priority over a simultaneous clear.
        err_pad_d = pad_set | (err_pad_q & ~CLR_ERR);
        err_blk_d = blk_set | (err_blk_q & ~CLR_ERR);
        err_len_d = len_set | (err_len_q & ~CLR_ERR);
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= IDLE;
            l1p_q      <= '0;
            blk_q      <= '0;
            l1aph_q    <= 1'b0;
            lctph_q    <= 1'b0;
            scaf_q     <= 1'b0;
            ovlp_q     <= 1'b0;
            smp_cnt_q  <= '0;
            evt_smps_q <= '0;
            hdr_vld_q  <= 1'b0;
            evt_done_q <= 1'b0;
            err_pad_q  <= 1'b0;
            err_blk_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            l1p_q      <= l1p_d;
            blk_q      <= blk_d;
            l1aph_q    <= l1aph_d;
            lctph_q    <= lctph_d;
            scaf_q     <= scaf_d;
            ovlp_q     <= ovlp_d;
            smp_cnt_q  <= smp_cnt_d;
            evt_smps_q <= evt_smps_d;
            hdr_vld_q  <= hdr_vld_d;
            evt_done_q <= evt_done_d;
            err_pad_q  <= err_pad_d;
            err_blk_q  <= err_blk_d;
            err_len_q  <= err_len_d;
        end
    end

    assign HDR_VLD   = hdr_vld_q;
    assign L1P       = l1p_q;
    assign BLK_ADR   = blk_q;
    assign L1A_PHASE = l1aph_q;
    assign LCT_PHASE = lctph_q;
    assign SCAFULL   = scaf_q;
    assign OVLP      = ovlp_q;
    assign SMP_CNT   = smp_cnt_q;
    assign EVT_DONE  = evt_done_q;
    assign EVT_SMPS  = evt_smps_q;
    assign ERR_PAD   = err_pad_q;
    assign ERR_BLK   = err_blk_q;
    assign ERR_LEN   = err_len_q;
    assign DBG_STATE = state_q;

endmodule

// File: doc/cfeb_hdr_rcvr.md
# cfeb_hdr_rcvr

Receive side of the CFEB per-sample serial header. It deserializes the D13 bit stream and D14 overlap flag that accompany each readout word strobe (PUSH). It reconstructs the per-sample header fields (L1A bin pattern, SCA block, phase bits, SCA-full, overlap) and tracks samples per event until LASTWORD. It sits on the collector side of the CFEB data link, in parallel with the ADC word path, and feeds event builders and error monitors.

## Interface
Parameters:
- MAX_SMPS, 8: maximum samples per event; exceeding it is a length error (range 1..15).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_B  in  1  asynchronous, active-low reset.
- PUSH  in  1  word strobe; one readout word per high cycle; gaps allowed.
- D13IN  in  1  serial header bit; valid only when PUSH=1.
- D14IN  in  1  inverted overlap flag (1 = no overlap); valid when PUSH=1.
- LASTWORD  in  1  marks the final PUSH of an event; ignored unless PUSH=1.
- CLR_ERR  in  1  clears sticky error flags.
- HDR_VLD  out  1  one-cycle pulse; header fields updated.
- L1P  out  8  L1A bin pattern of last completed sample.
- BLK_ADR  out  4  SCA block address.
- L1A_PHASE, LCT_PHASE, SCAFULL  out  1 each  decoded header bits.
- OVLP  out  1  overlap flag for the sample (= !D14IN captured at word 15).
- SMP_CNT  out  4  completed samples in the current event.
- EVT_DONE  out  1  one-cycle pulse at event end.
- EVT_SMPS  out  4  sample count of the finished event; held until the next EVT_DONE.
- ERR_PAD, ERR_BLK, ERR_LEN  out  1 each  sticky error flags.

## Operation
- Word index W (4 bits) counts PUSH cycles within a sample: 0..15, then wraps to 0.
- D13IN bit mapping:
  - W=0..7 → L1P[W].
  - W=8..11 → BLK_ADR[W-8].
  - W=12 → L1A_PHASE.
  - W=13 → LCT_PHASE.
  - W=14 → SCAFULL.
  - W=15 → pad, required 0.
- Bits shift into a 16-bit shadow register. Outputs update atomically at sample completion (W=15 with PUSH), so partially assembled fields are never visible.
- States:
  - IDLE: on the first PUSH, go to COLLECT with W=1.
  - COLLECT: accumulate. At PUSH with W=15, complete the sample and increment SMP_CNT (saturating at 15).
    - LASTWORD at W=15 → EVT_DONE, then IDLE.
    - Otherwise stay in COLLECT with W=0.
  - LASTWORD with PUSH at any W≠15 → ERR_LEN, EVT_DONE, EVT_SMPS = completed samples; partial sample discarded, no HDR_VLD; → IDLE.
- SMP_CNT clears on entry to IDLE. EVT_SMPS captures the final count, including the sample completed with LASTWORD.
- Error conditions:
  - ERR_LEN: completed samples > MAX_SMPS.
  - ERR_PAD: pad bit = 1.
  - ERR_BLK: BLK_ADR of sample n>0 differs from sample 0 of the same event.
- Errors are sticky until CLR_ERR. If a set condition and CLR_ERR occur in the same cycle, set wins.

## Timing
- Reset values: HDR_VLD=0, EVT_DONE=0, all fields 0, SMP_CNT=0, EVT_SMPS=0, errors 0, state IDLE, W=0.
- HDR_VLD and the updated fields appear one cycle after the 16th PUSH. EVT_DONE is asserted in the same cycle as the final HDR_VLD.
- Back-to-back events: a PUSH in the cycle after LASTWORD starts a new event. It is counted as W=0 directly, with no lost bit.
- Reset mid-frame discards the shadow register and counts immediately; no output pulse is produced.
- PUSH=0 cycles freeze all state.

## Configuration
- HDR_CHK_EN defined: ERR_PAD and ERR_BLK are generated as described, and the first-sample block register is present.
- HDR_CHK_EN undefined: ERR_PAD and ERR_BLK are tied 0 and the block register is removed. ERR_LEN is always present.

## Structure
- Shared package cfeb_hdr_pkg holds:
  - field bit positions (L1P_LSB=0, BLK_LSB=8, L1APH_BIT=12, LCTPH_BIT=13, SCAF_BIT=14, PAD_BIT=15);
  - HDR_WORDS=16;
  - the state enum {IDLE, COLLECT}.
- One sub-module, cfeb_hdr_shreg: 16-bit shift register with a word counter. Outputs are the parallel word and a done strobe. The top level holds the FSM, sample/event counters, checks and output registers.

## Test plan
- Single sample: 16 PUSHes encoding L1P=0xA5, BLK=0x9, L1A_PHASE=1, LCT_PHASE=0, SCAFULL=0, pad 0, D14IN=0, LASTWORD on word 15 → HDR_VLD and EVT_DONE one cycle later; L1P=0xA5, BLK_ADR=9, OVLP=1, EVT_SMPS=1, no errors.
- Eight samples with random PUSH gaps, BLK constant=3 → 8 HDR_VLD pulses, EVT_SMPS=8, SMP_CNT back to 0.
- Sample 2 with BLK=4 after BLK=3 → ERR_BLK=1 with HDR_CHK_EN, 0 without; ERR_BLK stays set until a CLR_ERR pulse.
- LASTWORD at W=7 of sample 1 → ERR_LEN=1, EVT_DONE with EVT_SMPS=1, no HDR_VLD for the partial sample.
- Pad bit 1 on word 15 → ERR_PAD=1. CLR_ERR in the same cycle as a new pad error → ERR_PAD remains 1.
- RST_B low at W=10 → all outputs 0. The next 16 PUSHes decode as a fresh sample with SMP_CNT=1.
